// File: rtl/signed_minmax_tracker.sv
// Streaming running max/min tracker with per-frame result handshake.
// Each accepted sample is compared against the frame's running extremes
// in signed or unsigned order. The frame's order is fixed by signed_mode
// on its first sample. A frame closes on in_last or at FRAME_LEN samples.
// Its max/min, their positions and the sample count are then held on the
// output side until the consumer takes them.
module signed_minmax_tracker #(
    parameter  int WIDTH     = 8,
    parameter  int FRAME_LEN = 16,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             signed_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CW-1:0]    out_max_idx,
    output logic [CW-1:0]    out_min_idx,
    output logic [CW-1:0]    out_cnt
);

    // IDLE: no partial frame; ACC: frame in progress; HOLD: result pending.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

    // Maps a sample onto an unsigned key so one magnitude comparator serves
    // both modes: flipping the sign bit turns two's-complement order into
    // plain unsigned order.
    function automatic logic [WIDTH-1:0] cmp_key(input logic [WIDTH-1:0] v,
                                                 input logic             mode);
        return mode ? {~v[WIDTH-1], v[WIDTH-2:0]} : v;
    endfunction

    // State and frame accumulator
    state_e           state_q,      state_d;
    logic             frame_mode_q, frame_mode_d;
    logic [WIDTH-1:0] run_max_q,    run_max_d;
    logic [WIDTH-1:0] run_min_q,    run_min_d;
    logic [CW-1:0]    max_idx_q,    max_idx_d;
    logic [CW-1:0]    min_idx_q,    min_idx_d;
    logic [CW-1:0]    cnt_q,        cnt_d;

    // Result registers
    logic [WIDTH-1:0] res_max_q,    res_max_d;
    logic [WIDTH-1:0] res_min_q,    res_min_d;
    logic [CW-1:0]    res_max_idx_q, res_max_idx_d;
    logic [CW-1:0]    res_min_idx_q, res_min_idx_d;
    logic [CW-1:0]    res_cnt_q,    res_cnt_d;

    // Merged view of the frame including the sample currently offered
    logic             accept;
    logic             first;
    logic             mode_eff;
    logic             is_gt;
    logic             is_lt;
    logic             frame_end;
    logic [WIDTH-1:0] mrg_max;
    logic [WIDTH-1:0] mrg_min;
    logic [CW-1:0]    mrg_max_idx;
    logic [CW-1:0]    mrg_min_idx;
    logic [CW-1:0]    mrg_cnt;

    assign out_valid   = (state_q == ST_HOLD);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

    assign out_max     = res_max_q;
    assign out_min     = res_min_q;
    assign out_max_idx = res_max_idx_q;
    assign out_min_idx = res_min_idx_q;
    assign out_cnt     = res_cnt_q;

    // Merge the offered sample into the running extremes. A sample arriving
    // outside ACC starts a fresh frame, including one accepted on the same
    // edge that the previous result is taken.
    always_comb begin
        first    = (state_q != ST_ACC);
        mode_eff = first ? signed_mode : frame_mode_q;
        // Strict compares keep the earliest position on ties.
        is_gt    = cmp_key(in_data, mode_eff) > cmp_key(run_max_q, mode_eff);
        is_lt    = cmp_key(in_data, mode_eff) < cmp_key(run_min_q, mode_eff);

        if (first) begin
            mrg_max     = in_data;
            mrg_min     = in_data;
            mrg_max_idx = '0;
            mrg_min_idx = '0;
            mrg_cnt     = CW'(1);
        end else begin
            mrg_max     = is_gt ? in_data : run_max_q;
            mrg_min     = is_lt ? in_data : run_min_q;
            mrg_max_idx = is_gt ? cnt_q   : max_idx_q;
            mrg_min_idx = is_lt ? cnt_q   : min_idx_q;
            mrg_cnt     = cnt_q + CW'(1);
        end

        frame_end = in_last || (mrg_cnt == FRAME_LEN_C);
    end

    // Next-state and register-load decisions for frame and result registers
    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this
        // block leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        frame_mode_d  = frame_mode_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        max_idx_d     = max_idx_q;
        min_idx_d     = min_idx_q;
        cnt_d         = cnt_q;
        res_max_d     = res_max_q;
        res_min_d     = res_min_q;
        res_max_idx_d = res_max_idx_q;
        res_min_idx_d = res_min_idx_q;
        res_cnt_d     = res_cnt_q;

        // Result taken: release HOLD. A sample accepted on this same edge
        // overrides the IDLE choice below.
        if (state_q == ST_HOLD && out_ready) begin
            state_d = ST_IDLE;
        end

        if (accept) begin
            frame_mode_d = mode_eff;
            run_max_d    = mrg_max;
            run_min_d    = mrg_min;
            max_idx_d    = mrg_max_idx;
            min_idx_d    = mrg_min_idx;
            cnt_d        = mrg_cnt;

            if (frame_end) begin
                state_d       = ST_HOLD;
                res_max_d     = mrg_max;
                res_min_d     = mrg_min;
                res_max_idx_d = mrg_max_idx;
                res_min_idx_d = mrg_min_idx;
                res_cnt_d     = mrg_cnt;
            end else begin
                state_d = ST_ACC;
            end
        end
    end

    // Register update with synchronous reset that discards any partial frame
    // or pending result.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            frame_mode_q  <= 1'b0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            cnt_q         <= '0;
            res_max_q     <= '0;
            res_min_q     <= '0;
            res_max_idx_q <= '0;
            res_min_idx_q <= '0;
            res_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            frame_mode_q  <= frame_mode_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            max_idx_q     <= max_idx_d;
            min_idx_q     <= min_idx_d;
            cnt_q         <= cnt_d;
            res_max_q     <= res_max_d;
            res_min_q     <= res_min_d;
            res_max_idx_q <= res_max_idx_d;
            res_min_idx_q <= res_min_idx_d;
            res_cnt_q     <= res_cnt_d;
        end
    end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Directed bench for signed_minmax_tracker (WIDTH=8, FRAME_LEN=4).
module tb_signed_minmax_tracker;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CW        = $clog2(FRAME_LEN + 1);

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             signed_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [CW-1:0]    out_max_idx;
    logic [CW-1:0]    out_min_idx;
    logic [CW-1:0]    out_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    signed_minmax_tracker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .out_cnt     (out_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Checks the whole result bundle.
    task automatic check_res(input string tag, input logic v,
                             input logic [7:0] mx, input int mxi,
                             input logic [7:0] mn, input int mni, input int cnt);
        check({tag, "_valid"},   32'(out_valid),   32'(v));
        check({tag, "_max"},     32'(out_max),     32'(mx));
        check({tag, "_max_idx"}, 32'(out_max_idx), 32'(mxi));
        check({tag, "_min"},     32'(out_min),     32'(mn));
        check({tag, "_min_idx"}, 32'(out_min_idx), 32'(mni));
        check({tag, "_cnt"},     32'(out_cnt),     32'(cnt));
    endtask

    // Offers one sample and returns #1 after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic last);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 20) begin
            @(posedge sys_clk); #1;
            w++;
        end
        if (w >= 20) check("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    logic [7:0] b2b [8];

    initial begin
        sys_rst     = 1'b1;
        signed_mode = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;

        // Reset state
        check_res("rst", 1'b0, 8'h00, 0, 8'h00, 0, 0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Signed frame: 7F largest, 80 smallest
        signed_mode = 1'b1;
        send(8'h7F, 1'b0);
        check("t1_no_early_valid", 32'(out_valid), 32'd0);
        send(8'h80, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        check_res("t1", 1'b1, 8'h7F, 0, 8'h80, 1, 4);

        // Unsigned frame; mid-frame switch to signed must be ignored
        signed_mode = 1'b0;
        send(8'h7F, 1'b0);
        send(8'h80, 1'b0);
        signed_mode = 1'b1;
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        check_res("t2", 1'b1, 8'hFF, 3, 8'h00, 2, 4);

        // Drain; stray in_last without in_valid is ignored
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("t2_drain_valid", 32'(out_valid), 32'd0);

        // All ties: first occurrence wins
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        check_res("t3", 1'b1, 8'h05, 0, 8'h05, 0, 4);
        tick();

        // Short frame with consumer stalled
        out_ready = 1'b0;
        send(8'h10, 1'b0);
        send(8'hF0, 1'b1);
        check_res("t4", 1'b1, 8'h10, 0, 8'hF0, 1, 2);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_ready", 32'(in_ready), 32'd0);
            check_res("t4_stall", 1'b1, 8'h10, 0, 8'hF0, 1, 2);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t4_release_ready", 32'(in_ready), 32'd1);
        tick();
        check_res("t4_released", 1'b0, 8'h10, 0, 8'hF0, 1, 2);

        // Back-to-back frames, no bubble; frame 2 has a signed min tie
        b2b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h83, 8'h10, 8'h83, 8'h90};
        signed_mode = 1'b1;
        in_valid    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = b2b[i];
            check("t5_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 3)      check_res("t5_f1", 1'b1, 8'h04, 3, 8'h01, 0, 4);
            else if (i == 7) check_res("t5_f2", 1'b1, 8'h10, 1, 8'h83, 0, 4);
            else             check("t5_gap_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check("t5_drain_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a frame discards it
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_res("t6_rst", 1'b0, 8'h00, 0, 8'h00, 0, 0);
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check("t6_no_stale_valid", 32'(out_valid), 32'd0);
        send(8'h04, 1'b0);
        check_res("t6", 1'b1, 8'h04, 3, 8'h01, 0, 4);

        // One-sample frame completing on the same edge as the handshake
        send(8'h42, 1'b1);
        check_res("t7", 1'b1, 8'h42, 0, 8'h42, 0, 1);
        tick();
        check("t7_drain_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
